// File: rtl/axi_lite_if.sv
// axi_lite_if: AXI4-Lite channel bundle between one master and one slave.
// Parameters: ADDR_WIDTH, DATA_WIDTH.
// Channels: AW (awaddr/awvalid/awready), W (wdata/wstrb/wvalid/wready),
//           B (bresp/bvalid/bready), AR (araddr/arvalid/arready),
//           R (rdata/rresp/rvalid/rready).
// Modports: master drives the valids, addresses, write data and B/R readys;
//           slave drives the A/W readys, responses and read data.
interface axi_lite_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_imem_system.sv
// axi_lite_imem_system: single-transaction AXI4-Lite master looped onto a
// word-addressed memory slave. Each start pulse performs one fixed write
// (WR_ADDR/WR_DATA) or one read (RD_ADDR); the last read word is held.
// Ports: aclk, areset_n (async, active-low), start_write, start_read,
//        rdata (last read word), busy (master not idle),
//        wr_done / rd_done (one-cycle pulses on B / R handshakes).

module axi_lite_master #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] WR_ADDR    = 32'h4,
    parameter logic [DATA_WIDTH-1:0] WR_DATA    = 32'hdeadbeef,
    parameter logic [ADDR_WIDTH-1:0] RD_ADDR    = 32'h4
) (
    input  logic                  aclk,
    input  logic                  areset_n,
    input  logic                  start_write,
    input  logic                  start_read,
    axi_lite_if.master            bus,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy,
    output logic                  wr_done,
    output logic                  rd_done
);
    typedef enum logic [2:0] {S_IDLE, S_WR, S_WRESP, S_RD_ADDR, S_RD_DATA} state_t;
    state_t state;

    // Responses are always OKAY from this slave; nothing acts on them.
    logic unused_resp;
    assign unused_resp = ^{bus.bresp, bus.rresp};

    assign busy = (state != S_IDLE);

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state       <= S_IDLE;
            bus.awaddr  <= '0;
            bus.awvalid <= 1'b0;
            bus.wdata   <= '0;
            bus.wstrb   <= '0;
            bus.wvalid  <= 1'b0;
            bus.bready  <= 1'b0;
            bus.araddr  <= '0;
            bus.arvalid <= 1'b0;
            bus.rready  <= 1'b0;
            rdata       <= '0;
            wr_done     <= 1'b0;
            rd_done     <= 1'b0;
        end else begin
            wr_done <= 1'b0;
            rd_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Write has priority; a simultaneous read request is dropped.
                    if (start_write) begin
                        bus.awaddr  <= WR_ADDR;
                        bus.wdata   <= WR_DATA;
                        bus.wstrb   <= '1;
                        bus.awvalid <= 1'b1;
                        bus.wvalid  <= 1'b1;
                        state       <= S_WR;
                    end else if (start_read) begin
                        bus.araddr  <= RD_ADDR;
                        bus.arvalid <= 1'b1;
                        state       <= S_RD_ADDR;
                    end
                end
                S_WR: begin
                    if (bus.awvalid && bus.awready) bus.awvalid <= 1'b0;
                    if (bus.wvalid && bus.wready)   bus.wvalid  <= 1'b0;
                    // A channel is finished once its valid is gone or handshaking now.
                    if ((!bus.awvalid || bus.awready) && (!bus.wvalid || bus.wready)) begin
                        bus.bready <= 1'b1;
                        state      <= S_WRESP;
                    end
                end
                S_WRESP: begin
                    if (bus.bvalid) begin
                        bus.bready <= 1'b0;
                        wr_done    <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                S_RD_ADDR: begin
                    if (bus.arready) begin
                        bus.arvalid <= 1'b0;
                        bus.rready  <= 1'b1;
                        state       <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (bus.rvalid) begin
                        bus.rready <= 1'b0;
                        rdata      <= bus.rdata;
                        rd_done    <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

module axi_lite_imem #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 64
) (
    input  logic      aclk,
    input  logic      areset_n,
    axi_lite_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int NBYTE = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] imem [0:DEPTH-1];

    // AW and W may complete in different cycles; hold whichever arrived first.
    logic                  aw_got, w_got;
    logic [IDX_W-1:0]      aw_idx_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [NBYTE-1:0]      wstrb_q;

    logic                  aw_hs, w_hs, wr_fire;
    logic [IDX_W-1:0]      wr_idx;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [NBYTE-1:0]      wr_strb;

    // Addresses are word indices; upper bits wrap away.
    logic unused_addr;
    assign unused_addr = ^{bus.awaddr[ADDR_WIDTH-1:IDX_W], bus.araddr[ADDR_WIDTH-1:IDX_W]};

    always_comb begin
        aw_hs   = bus.awvalid && bus.awready;
        w_hs    = bus.wvalid && bus.wready;
        wr_idx  = aw_hs ? bus.awaddr[IDX_W-1:0] : aw_idx_q;
        wr_data = w_hs ? bus.wdata : wdata_q;
        wr_strb = w_hs ? bus.wstrb : wstrb_q;
        wr_fire = (aw_hs || aw_got) && (w_hs || w_got);
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            bus.awready <= 1'b0;
            bus.wready  <= 1'b0;
            bus.bvalid  <= 1'b0;
            bus.bresp   <= '0;
            bus.arready <= 1'b0;
            bus.rvalid  <= 1'b0;
            bus.rresp   <= '0;
            bus.rdata   <= '0;
            aw_got      <= 1'b0;
            w_got       <= 1'b0;
            aw_idx_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) imem[i] <= '0;
        end else begin
            bus.awready <= bus.awvalid && !bus.awready && !bus.bvalid && !aw_got;
            bus.wready  <= bus.wvalid && !bus.wready && !bus.bvalid && !w_got;
            bus.arready <= bus.arvalid && !bus.arready && !bus.rvalid;

            if (aw_hs) begin
                aw_got   <= 1'b1;
                aw_idx_q <= bus.awaddr[IDX_W-1:0];
            end
            if (w_hs) begin
                w_got   <= 1'b1;
                wdata_q <= bus.wdata;
                wstrb_q <= bus.wstrb;
            end

            if (wr_fire) begin
                for (int unsigned b = 0; b < NBYTE; b++) begin
                    if (wr_strb[b]) imem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
                aw_got     <= 1'b0;
                w_got      <= 1'b0;
                bus.bvalid <= 1'b1;
                bus.bresp  <= 2'b00;
            end else if (bus.bvalid && bus.bready) begin
                bus.bvalid <= 1'b0;
            end

            if (bus.arvalid && bus.arready) begin
                bus.rdata  <= imem[bus.araddr[IDX_W-1:0]];
                bus.rresp  <= 2'b00;
                bus.rvalid <= 1'b1;
            end else if (bus.rvalid && bus.rready) begin
                bus.rvalid <= 1'b0;
            end
        end
    end
endmodule

module axi_lite_imem_system #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 64,
    parameter logic [ADDR_WIDTH-1:0] WR_ADDR    = 32'h4,
    parameter logic [DATA_WIDTH-1:0] WR_DATA    = 32'hdeadbeef,
    parameter logic [ADDR_WIDTH-1:0] RD_ADDR    = 32'h4
) (
    input  logic                  aclk,
    input  logic                  areset_n,
    input  logic                  start_write,
    input  logic                  start_read,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy,
    output logic                  wr_done,
    output logic                  rd_done
);
    axi_lite_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) bus ();

    axi_lite_master #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .WR_ADDR   (WR_ADDR),
        .WR_DATA   (WR_DATA),
        .RD_ADDR   (RD_ADDR)
    ) u_master (
        .aclk       (aclk),
        .areset_n   (areset_n),
        .start_write(start_write),
        .start_read (start_read),
        .bus        (bus),
        .rdata      (rdata),
        .busy       (busy),
        .wr_done    (wr_done),
        .rd_done    (rd_done)
    );

    axi_lite_imem #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
    ) u_mem (
        .aclk    (aclk),
        .areset_n(areset_n),
        .bus     (bus)
    );
endmodule

// File: tb/tb_axi_lite_imem_system.sv
// Testbench for axi_lite_imem_system: expected write/read results are queued
// when a start pulse is driven and retired when wr_done / rd_done appear.
module tb_axi_lite_imem_system;
    logic        aclk = 1'b0;
    logic        areset_n = 1'b1;
    logic        start_write = 1'b0;
    logic        start_read = 1'b0;
    logic [31:0] rdata;
    logic        busy, wr_done, rd_done;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int          cyc = 0;
    int          t_wr = 0, t_rd = 0;
    int          wr_cnt = 0, rd_cnt = 0, bhs_cnt = 0;
    int          wr_base, rd_base, bhs_base;
    logic [31:0] wr_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] model_m4;
    logic [31:0] e_wr, e_rd;

    axi_lite_imem_system #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .DEPTH     (64),
        .WR_ADDR   (32'h4),
        .WR_DATA   (32'hdeadbeef),
        .RD_ADDR   (32'h4)
    ) dut (
        .aclk       (aclk),
        .areset_n   (areset_n),
        .start_write(start_write),
        .start_read (start_read),
        .rdata      (rdata),
        .busy       (busy),
        .wr_done    (wr_done),
        .rd_done    (rd_done)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard side: retire queued expectations as the DUT completes.
    always @(negedge aclk) begin
        if (areset_n) begin
            if (wr_done) begin
                wr_cnt++;
                check_val("wr_latency", 32'(cyc - t_wr), 32'd4);
                check_val("wr_expected", 32'(wr_q.size() != 0), 32'd1);
                if (wr_q.size() != 0) begin
                    e_wr = wr_q.pop_front();
                    check_val("imem4_after_wr", dut.u_mem.imem[4], e_wr);
                end
            end
            if (rd_done) begin
                rd_cnt++;
                check_val("rd_latency", 32'(cyc - t_rd), 32'd4);
                check_val("rd_expected", 32'(rd_q.size() != 0), 32'd1);
                if (rd_q.size() != 0) begin
                    e_rd = rd_q.pop_front();
                    check_val("rdata", rdata, e_rd);
                end
            end
            if (dut.bus.bvalid && dut.bus.bready) begin
                bhs_cnt++;
                check_val("bresp", 32'(dut.bus.bresp), 32'd0);
            end
            if (dut.bus.rvalid && dut.bus.rready)
                check_val("rresp", 32'(dut.bus.rresp), 32'd0);
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge aclk);
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic pulse(input logic w, input logic r);
        start_write = w;
        start_read  = r;
        if (w) t_wr = cyc;
        if (r) t_rd = cyc;
        @(negedge aclk);
        start_write = 1'b0;
        start_read  = 1'b0;
    endtask

    task automatic do_reset();
        areset_n = 1'b0;
        wr_q.delete();
        rd_q.delete();
        wait_cycles(2);
        areset_n = 1'b1;
        model_m4 = 32'h0;
        @(negedge aclk);
        check_val("rst_rdata", rdata, 32'h0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_imem4", dut.u_mem.imem[4], 32'h0);
        check_val("rst_valids", 32'({dut.bus.awvalid, dut.bus.wvalid, dut.bus.arvalid,
                                     dut.bus.bvalid, dut.bus.rvalid}), 32'd0);
    endtask

    initial begin
        @(negedge aclk);
        do_reset();

        // Read with no prior write returns zero.
        rd_base = rd_cnt;
        rd_q.push_back(model_m4);
        pulse(1'b0, 1'b1);
        check_val("busy_rd", 32'(busy), 32'd1);
        wait_cycles(10);
        check_val("rd_cnt_empty", 32'(rd_cnt - rd_base), 32'd1);

        // Plain write.
        wr_base = wr_cnt;
        model_m4 = 32'hdeadbeef;
        wr_q.push_back(model_m4);
        pulse(1'b1, 1'b0);
        check_val("busy_wr", 32'(busy), 32'd1);
        check_val("awvalid_n1", 32'(dut.bus.awvalid && dut.bus.wvalid), 32'd1);
        wait_cycles(10);
        check_val("wr_cnt", 32'(wr_cnt - wr_base), 32'd1);
        check_val("busy_after_wr", 32'(busy), 32'd0);

        // Read back the written word.
        rd_base = rd_cnt;
        rd_q.push_back(model_m4);
        pulse(1'b0, 1'b1);
        wait_cycles(10);
        check_val("rd_cnt_back", 32'(rd_cnt - rd_base), 32'd1);

        // Reset clears memory and rdata; simultaneous starts: write wins.
        do_reset();
        wr_base = wr_cnt;
        rd_base = rd_cnt;
        model_m4 = 32'hdeadbeef;
        wr_q.push_back(model_m4);
        pulse(1'b1, 1'b1);
        wait_cycles(10);
        check_val("both_wr_cnt", 32'(wr_cnt - wr_base), 32'd1);
        check_val("both_rd_cnt", 32'(rd_cnt - rd_base), 32'd0);
        rd_q.push_back(model_m4);
        pulse(1'b0, 1'b1);
        wait_cycles(10);
        check_val("both_later_rd", 32'(rd_cnt - rd_base), 32'd1);

        // Read requested while busy writing is ignored.
        do_reset();
        wr_base = wr_cnt;
        rd_base = rd_cnt;
        model_m4 = 32'hdeadbeef;
        wr_q.push_back(model_m4);
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        wait_cycles(10);
        check_val("busy_ign_wr", 32'(wr_cnt - wr_base), 32'd1);
        check_val("busy_ign_rd", 32'(rd_cnt - rd_base), 32'd0);

        // Reset during N+1 of a write abandons it.
        do_reset();
        wr_base  = wr_cnt;
        bhs_base = bhs_cnt;
        pulse(1'b1, 1'b0);
        areset_n = 1'b0;
        #1;
        check_val("midrst_busy", 32'(busy), 32'd0);
        check_val("midrst_awvalid", 32'(dut.bus.awvalid), 32'd0);
        wait_cycles(2);
        areset_n = 1'b1;
        wait_cycles(10);
        check_val("midrst_imem4", dut.u_mem.imem[4], 32'h0);
        check_val("midrst_bhs", 32'(bhs_cnt - bhs_base), 32'd0);
        check_val("midrst_wr_cnt", 32'(wr_cnt - wr_base), 32'd0);
        check_val("midrst_rdata", rdata, 32'h0);

        check_val("wr_q_drained", 32'(wr_q.size()), 32'd0);
        check_val("rd_q_drained", 32'(rd_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
